tmds_channel_decoder: RTL and testbench
=======================================

// Module: tmds_channel_decoder
// PURPOSE
//  Receive-side counterpart of the TMDS encoder: one decoder per TMDS channel.
//  Deserializes the serial TMDS bit stream (LSB first) and finds the 10-bit word boundary from control tokens.
//  Decodes each 10-bit word back to 8-bit pixel data, or to the 2-bit control field {C1,C0} during blanking.
//  Used in the loopback test receiver; channel 0 ctrl = {vsync,hsync}.
// PARAMETERS
//  LOCK_COUNT    4            consecutive aligned control tokens required to declare lock
//  MAX_DATA_RUN  2048         consecutive non-control words tolerated in LOCKED before unlock
//  GUARD_WORD    10'h2CC      guard-band code for this channel (10'b1011001100; ch1 uses 10'h133)
// PORTS
//  clk         in   1   bit clock (10x pixel rate), rising edge
//  s_rst       in   1   synchronous reset, active-high
//  serial_in   in   1   TMDS serial bit (positive leg), one bit per clk
//  word_valid  out  1   1-cycle pulse: pixel_data/ctrl/de/guard updated
//  pixel_data  out  8   decoded data byte (valid when de=1)
//  ctrl        out  2   {C1,C0} from last control token (held between tokens)
//  de          out  1   data enable: 1 = data word, 0 = control/guard word
//  guard       out  1   guard-band word flag (only with GUARD_DETECT_EN)
//  locked      out  1   word alignment established
// BEHAVIOUR
//  - Reset: all outputs 0, state UNLOCKED, bit_cnt=0, match_cnt=0, run_cnt=0. s_rst wins over every other event; reset mid-word discards the partial word.
//  - Shift: sr_next = {serial_in, sr[9:1]}; sr <= sr_next every clk. The first bit received is q[0].
//  - Control tokens, written as q[9:0]: 0x354 = {C1,C0} 00, 0x0AB = 01, 0x154 = 10, 0x2AB = 11.
//  - FSM:
//    - UNLOCKED: every clk test sr_next; on a token, bit_cnt<=0, match_cnt<=1, go to CANDIDATE. No word_valid.
//    - CANDIDATE: bit_cnt counts 0..9 and wraps. On the edge with bit_cnt==9 (the word boundary), test sr_next:
//      - token: match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED, locked<=1, run_cnt<=0.
//      - non-token: go to UNLOCKED, match_cnt<=0.
//      - No word_valid in CANDIDATE, including on the locking word.
//    - LOCKED: at each boundary, word_valid<=1 for one cycle and the word is decoded.
//      - Token: ctrl<=code, de<=0, run_cnt<=0.
//      - Otherwise run_cnt++. The boundary on which run_cnt would reach MAX_DATA_RUN goes to UNLOCKED: locked<=0, no word_valid, outputs hold.
//      - No realignment while LOCKED.
//  - Decode (q=sr_next):
//    - q' = q[9] ? ~q[7:0] : q[7:0].
//    - d[0] = q'[0].
//    - d[i] = q[8] ? q'[i]^q'[i-1] : ~(q'[i]^q'[i-1]) for i=1..7.
//    - Data word: pixel_data<=d, de<=1, ctrl holds. On control words pixel_data holds.
//  - Latency: outputs registered on the same edge that samples bit 9 of the word, so they are visible the next cycle.
//  - Inter-pulse spacing of word_valid is exactly 10 clk while LOCKED.
//  - run_cnt width $clog2(MAX_DATA_RUN+1); it never wraps.
// CONFIGURATION
//  GUARD_DETECT_EN defined:
//    - LOCKED boundary word == GUARD_WORD -> guard<=1, de<=0, pixel_data holds, run_cnt++.
//    - Any other word -> guard<=0.
//  GUARD_DETECT_EN undefined: guard tied 0; the guard word decodes as ordinary data (0x2CC -> 0xAB, de=1).
// TESTING
//  1. s_rst=1 for 3 clk with random serial_in -> all outputs 0, locked=0, no word_valid.
//  2. Lock acquisition:
//     - Stimulus: 7 random bits, then 4x 0x354 LSB-first, then 0x0AB.
//     - locked=1 after the 4th token boundary.
//     - Next boundary: word_valid=1, ctrl=2'b01, de=0.
//  3. Data decode when locked:
//     - 0x100 -> pixel_data=0x00, de=1.
//     - 0x200 -> 0xFF, de=1.
//     - word_valid spacing exactly 10 clk.
//  4. Unlock: MAX_DATA_RUN=8; after lock send 8 data words with no token -> locked=0 on the 8th boundary, 7 word_valid pulses only.
//  5. False candidate: one 0x2AB then a data word at the next boundary -> state back to UNLOCKED, locked stays 0, no word_valid.
//  6. Guard word 0x2CC when locked:
//     - With GUARD_DETECT_EN: guard=1, de=0.
//     - Without: pixel_data=0xAB, de=1, guard=0.
//     - Also s_rst asserted mid-word while LOCKED -> locked=0 next cycle.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// -----------------------------------------------------------------------------
// tmds_channel_decoder
//   Receive side of one TMDS channel. Shifts the serial stream in LSB first,
//   finds the 10-bit word boundary by looking for repeated control tokens, and
//   then decodes every aligned word into a pixel byte or a {C1,C0} control
//   field.
//
//   Ports
//     clk         in   bit clock (10x pixel rate), rising edge
//     s_rst       in   synchronous reset, active-high
//     serial_in   in   TMDS serial bit, one per clk
//     word_valid  out  one-cycle pulse when pixel_data/ctrl/de/guard update
//     pixel_data  out  decoded data byte (meaningful when de=1)
//     ctrl        out  {C1,C0} of the last control token (held)
//     de          out  1 = data word, 0 = control/guard word
//     guard       out  guard-band word flag (constant 0 unless GUARD_DETECT_EN)
//     locked      out  word alignment established
//
//   Build option
//     GUARD_DETECT_EN : when defined, a locked boundary word equal to
//                       GUARD_WORD is flagged on guard instead of decoded.
//
//   LOCK_COUNT is expected to be at least 2 (the first token is what moves
//   the FSM out of UNLOCKED).
// -----------------------------------------------------------------------------
module tmds_channel_decoder #(
    parameter int         LOCK_COUNT   = 4,
    parameter int         MAX_DATA_RUN = 2048,
    parameter logic [9:0] GUARD_WORD   = 10'h2CC
) (
    input  logic       clk,
    input  logic       s_rst,
    input  logic       serial_in,
    output logic       word_valid,
    output logic [7:0] pixel_data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       guard,
    output logic       locked
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int RUN_W   = $clog2(MAX_DATA_RUN + 1);
    localparam logic [MATCH_W-1:0] LOCK_CNT_V = MATCH_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0]   RUN_MAX_V  = RUN_W'(MAX_DATA_RUN);

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_CANDIDATE = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    // True when q is one of the four control tokens.
    function automatic logic is_token(input logic [9:0] q);
        case (q)
            10'h354, 10'h0AB, 10'h154, 10'h2AB: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // {C1,C0} carried by a control token.
    function automatic logic [1:0] token_code(input logic [9:0] q);
        case (q)
            10'h354: return 2'b00;
            10'h0AB: return 2'b01;
            10'h154: return 2'b10;
            10'h2AB: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Undo the optional inversion (q[9]) and the XOR/XNOR chain (q[8]).
    function automatic logic [7:0] decode_word(input logic [9:0] q);
        logic [7:0] qi;
        logic [7:0] chain;
        logic [7:0] d;
        qi    = q[9] ? ~q[7:0] : q[7:0];
        chain = qi ^ {qi[6:0], 1'b0};
        d     = q[8] ? chain : ~chain;
        d[0]  = qi[0];
        return d;
    endfunction

    state_t             state_q, state_d;
    logic [9:0]         sr_q, sr_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic               word_valid_q, word_valid_d;
    logic [7:0]         pixel_data_q, pixel_data_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic               de_q, de_d;
    logic               guard_q, guard_d;
    logic               locked_q, locked_d;

    logic               boundary_s;
    logic               tok_s;
    logic [MATCH_W-1:0] match_inc_s;
    logic [RUN_W-1:0]   run_inc_s;

    // Next-state and output logic; decisions are made on sr_d so that the
    // outputs register on the same edge that samples bit 9 of the word.
    always_comb begin
        state_d      = state_q;
        sr_d         = {serial_in, sr_q[9:1]};
        bit_cnt_d    = (bit_cnt_q == 4'd9) ? 4'd0 : bit_cnt_q + 4'd1;
        match_cnt_d  = match_cnt_q;
        run_cnt_d    = run_cnt_q;
        word_valid_d = 1'b0;
        pixel_data_d = pixel_data_q;
        ctrl_d       = ctrl_q;
        de_d         = de_q;
        guard_d      = guard_q;
        locked_d     = locked_q;

        boundary_s   = (bit_cnt_q == 4'd9);
        tok_s        = is_token(sr_d);
        match_inc_s  = match_cnt_q + MATCH_W'(1);
        run_inc_s    = run_cnt_q + RUN_W'(1);

        case (state_q)
            ST_UNLOCKED: begin
                // Hunt on every bit; a token here defines the word phase.
                bit_cnt_d = 4'd0;
                if (tok_s) begin
                    state_d     = ST_CANDIDATE;
                    match_cnt_d = MATCH_W'(1);
                end else begin
                    match_cnt_d = '0;
                end
            end
            ST_CANDIDATE: begin
                if (!boundary_s) begin
                    state_d = ST_CANDIDATE;
                end else if (tok_s) begin
                    match_cnt_d = match_inc_s;
                    if (match_inc_s == LOCK_CNT_V) begin
                        state_d   = ST_LOCKED;
                        locked_d  = 1'b1;
                        run_cnt_d = '0;
                    end else begin
                        state_d = ST_CANDIDATE;
                    end
                end else begin
                    state_d     = ST_UNLOCKED;
                    match_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                if (!boundary_s) begin
                    state_d = ST_LOCKED;
                end else if (tok_s) begin
                    word_valid_d = 1'b1;
                    ctrl_d       = token_code(sr_d);
                    de_d         = 1'b0;
                    guard_d      = 1'b0;
                    run_cnt_d    = '0;
                end else if (run_inc_s == RUN_MAX_V) begin
                    // Too long without a token: drop alignment, outputs hold.
                    state_d     = ST_UNLOCKED;
                    locked_d    = 1'b0;
                    match_cnt_d = '0;
                    run_cnt_d   = '0;
                end else begin
                    run_cnt_d    = run_inc_s;
                    word_valid_d = 1'b1;
`ifdef GUARD_DETECT_EN
                    if (sr_d == GUARD_WORD) begin
                        guard_d = 1'b1;
                        de_d    = 1'b0;
                    end else begin
                        guard_d      = 1'b0;
                        de_d         = 1'b1;
                        pixel_data_d = decode_word(sr_d);
                    end
`else
                    de_d         = 1'b1;
                    pixel_data_d = decode_word(sr_d);
`endif
                end
            end
            default: begin
                state_d     = ST_UNLOCKED;
                locked_d    = 1'b0;
                match_cnt_d = '0;
                run_cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state_q      <= ST_UNLOCKED;
            sr_q         <= 10'd0;
            bit_cnt_q    <= 4'd0;
            match_cnt_q  <= '0;
            run_cnt_q    <= '0;
            word_valid_q <= 1'b0;
            pixel_data_q <= 8'd0;
            ctrl_q       <= 2'b00;
            de_q         <= 1'b0;
            guard_q      <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            match_cnt_q  <= match_cnt_d;
            run_cnt_q    <= run_cnt_d;
            word_valid_q <= word_valid_d;
            pixel_data_q <= pixel_data_d;
            ctrl_q       <= ctrl_d;
            de_q         <= de_d;
            guard_q      <= guard_d;
            locked_q     <= locked_d;
        end
    end

    assign word_valid = word_valid_q;
    assign pixel_data = pixel_data_q;
    assign ctrl       = ctrl_q;
    assign de         = de_q;
    assign guard      = guard_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
module tb_tmds_channel_decoder;

    localparam int         LOCK_N  = 4;
    localparam int         MAX_RUN = 8;
    localparam logic [9:0] GUARD   = 10'h2CC;
    localparam logic [9:0] TOKS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    logic       clk = 1'b0;
    logic       s_rst = 1'b1;
    logic       serial_in = 1'b0;
    logic       word_valid;
    logic [7:0] pixel_data;
    logic [1:0] ctrl;
    logic       de;
    logic       guard;
    logic       locked;

    int tests = 0;
    int fails = 0;

    tmds_channel_decoder #(
        .LOCK_COUNT  (LOCK_N),
        .MAX_DATA_RUN(MAX_RUN),
        .GUARD_WORD  (GUARD)
    ) dut (
        .clk       (clk),
        .s_rst     (s_rst),
        .serial_in (serial_in),
        .word_valid(word_valid),
        .pixel_data(pixel_data),
        .ctrl      (ctrl),
        .de        (de),
        .guard     (guard),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [9:0] m_win = 10'd0;
    bit         m_hunting = 1'b1;
    bit         m_locked = 1'b0;
    int         m_hits = 0;
    int         m_run = 0;
    int         m_nbit = 0;
    int         m_next = 0;
    logic       e_wv = 1'b0;
    logic [7:0] e_pix = 8'd0;
    logic [1:0] e_ctrl = 2'b00;
    logic       e_de = 1'b0;
    logic       e_guard = 1'b0;
    logic       e_locked = 1'b0;

    function automatic bit m_is_token(input logic [9:0] w, output logic [1:0] c);
        c = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (w == TOKS[i]) begin
                c = i[1:0];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Find the byte whose TMDS transition-minimised form matches the word.
    function automatic logic [7:0] m_decode(input logic [9:0] w);
        logic [7:0] target;
        logic [7:0] dd;
        logic [7:0] qm;
        target = w[9] ? ~w[7:0] : w[7:0];
        for (int d = 0; d < 256; d++) begin
            dd    = d[7:0];
            qm[0] = dd[0];
            for (int i = 1; i < 8; i++)
                qm[i] = w[8] ? (qm[i-1] ^ dd[i]) : ~(qm[i-1] ^ dd[i]);
            if (qm == target) return dd;
        end
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        logic       tok;
        logic [1:0] code;
        if (s_rst) begin
            m_win = 10'd0; m_hunting = 1'b1; m_locked = 1'b0;
            m_hits = 0; m_run = 0; m_nbit = 0; m_next = 0;
            e_wv = 1'b0; e_pix = 8'd0; e_ctrl = 2'b00; e_de = 1'b0;
            e_guard = 1'b0; e_locked = 1'b0;
        end else begin
            m_win = {serial_in, m_win[9:1]};
            e_wv  = 1'b0;
            tok   = m_is_token(m_win, code);
            if (m_hunting) begin
                if (tok) begin
                    m_hunting = 1'b0;
                    m_hits    = 1;
                    m_next    = m_nbit + 10;
                end
            end else if (m_nbit == m_next) begin
                m_next = m_next + 10;
                if (!m_locked) begin
                    if (tok) begin
                        m_hits++;
                        if (m_hits == LOCK_N) begin
                            m_locked = 1'b1; e_locked = 1'b1; m_run = 0;
                        end
                    end else begin
                        m_hunting = 1'b1; m_hits = 0;
                    end
                end else if (tok) begin
                    e_wv = 1'b1; e_ctrl = code; e_de = 1'b0; e_guard = 1'b0; m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == MAX_RUN) begin
                        m_locked = 1'b0; e_locked = 1'b0; m_hunting = 1'b1;
                        m_hits = 0; m_run = 0;
                    end else begin
                        e_wv = 1'b1;
`ifdef GUARD_DETECT_EN
                        if (m_win == GUARD) begin
                            e_guard = 1'b1; e_de = 1'b0;
                        end else begin
                            e_guard = 1'b0; e_de = 1'b1; e_pix = m_decode(m_win);
                        end
`else
                        e_de = 1'b1; e_pix = m_decode(m_win);
`endif
                    end
                end
            end
            m_nbit++;
        end
    end

    // ---------------- per-cycle compare ----------------
    int cyc = 0;
    int wv_count = 0;
    int last_wv = 0;
    int prev_wv = 0;

    always @(negedge clk) begin
        cyc++;
        tests++;
        if (word_valid !== e_wv || pixel_data !== e_pix || ctrl !== e_ctrl ||
            de !== e_de || guard !== e_guard || locked !== e_locked) begin
            fails++;
            $display("FAIL cycle%0d got wv=%b pix=%h ctrl=%b de=%b guard=%b locked=%b expected wv=%b pix=%h ctrl=%b de=%b guard=%b locked=%b",
                     cyc, word_valid, pixel_data, ctrl, de, guard, locked,
                     e_wv, e_pix, e_ctrl, e_de, e_guard, e_locked);
        end
        if (word_valid === 1'b1) begin
            wv_count++;
            prev_wv = last_wv;
            last_wv = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present one bit; returns just after the edge that sampled it has settled.
    task automatic tick(input logic b);
        serial_in = b;
        @(negedge clk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) tick(w[i]);
    endtask

    task automatic reset_and_lock();
        s_rst = 1'b1;
        tick(1'b0);
        s_rst = 1'b0;
        for (int i = 0; i < 7; i++) tick(1'b0);
        for (int i = 0; i < 4; i++) send_word(10'h354);
    endtask

    int snap;

    initial begin
        // 1. reset with random serial data
        s_rst = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(1, 0)));
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_wv", 32'(word_valid), 32'd0);
        chk("rst_outs", {20'd0, pixel_data, ctrl, de, guard}, 32'd0);

        // 2. lock acquisition
        reset_and_lock();
        chk("lock_locked", 32'(locked), 32'd1);
        chk("lock_no_wv", 32'(word_valid), 32'd0);
        send_word(10'h0AB);
        chk("tok_wv", 32'(word_valid), 32'd1);
        chk("tok_ctrl", 32'(ctrl), 32'd1);
        chk("tok_de", 32'(de), 32'd0);

        // 3. data decode
        send_word(10'h100);
        chk("d100_pix", 32'(pixel_data), 32'h00);
        chk("d100_de", 32'(de), 32'd1);
        send_word(10'h200);
        chk("d200_pix", 32'(pixel_data), 32'hFF);
        chk("d200_de", 32'(de), 32'd1);
        chk("wv_spacing", 32'(last_wv - prev_wv), 32'd10);

        // 4. unlock after MAX_RUN data words
        send_word(10'h354);
        chk("tok0_ctrl", 32'(ctrl), 32'd0);
        snap = wv_count;
        for (int i = 0; i < 8; i++) send_word(10'h100);
        chk("unlock_locked", 32'(locked), 32'd0);
        chk("unlock_pulses", 32'(wv_count - snap), 32'd7);

        // 5. false candidate
        s_rst = 1'b1;
        tick(1'b0);
        s_rst = 1'b0;
        for (int i = 0; i < 7; i++) tick(1'b0);
        snap = wv_count;
        send_word(10'h2AB);
        send_word(10'h100);
        chk("false_locked", 32'(locked), 32'd0);
        chk("false_pulses", 32'(wv_count - snap), 32'd0);
        for (int i = 0; i < 4; i++) send_word(10'h354);
        chk("relock_locked", 32'(locked), 32'd1);

        // 6. guard word and mid-word reset
        reset_and_lock();
        send_word(10'h2CC);
        chk("guard_wv", 32'(word_valid), 32'd1);
`ifdef GUARD_DETECT_EN
        chk("guard_flag", 32'(guard), 32'd1);
        chk("guard_de", 32'(de), 32'd0);
`else
        chk("guard_pix", 32'(pixel_data), 32'hAB);
        chk("guard_de", 32'(de), 32'd1);
        chk("guard_flag", 32'(guard), 32'd0);
`endif
        for (int i = 0; i < 5; i++) tick(1'b1);
        s_rst = 1'b1;
        tick(1'b0);
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_wv", 32'(word_valid), 32'd0);
        s_rst = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
